// File: rtl/gbcam_sensor_seq.sv
// Capture sequencer for an M64282FP-class image sensor: XCK generation, sensor reset,
// serial register programming, exposure timing and per-pixel readout strobes.
module gbcam_sensor_seq #(
    parameter int unsigned XCK_DIV = 4,
    parameter int unsigned PIXELS  = 16384
) (
    input  logic        sys_clock,
    input  logic        reset,
    input  logic        cap_req,
    input  logic        cap_abort,
    input  logic [63:0] cfg_regs,
    input  logic [15:0] cfg_exposure,
    output logic        cap_busy,
    output logic        cap_done,
    output logic        sens_xck,
    output logic        sens_reset,
    output logic        sens_load,
    output logic        sens_sin,
    output logic        sens_start,
    output logic        sens_read,
    output logic        pix_valid,
    output logic [13:0] pix_index
);
    typedef enum logic [2:0] {
        StIdle, StRst, StProg, StStart, StExpo, StRead, StDone
    } state_e;

    state_e      state;
    logic [7:0]  div_cnt;
    logic [63:0] regs_q;
    logic [15:0] expo_q;
    logic [15:0] expo_cnt;
    logic        rst_phase;
    logic        prog_end;
    logic [2:0]  word_idx;
    logic [3:0]  bit_idx;
    logic [14:0] pix_cnt;
    logic        wrap;
    logic        fall;
    logic        rise;
    logic        emit;
    logic [10:0] prog_word;

    assign wrap      = cap_busy && (div_cnt == 8'(XCK_DIV - 1));
    assign fall      = wrap && sens_xck;
    assign rise      = wrap && !sens_xck;
    assign prog_word = {word_idx, regs_q[{word_idx, 3'b000} +: 8]};
    // The first serial bit leaves on the same fall that releases sensor reset.
    assign emit      = fall && ((state == StRst && rst_phase) || (state == StProg && !prog_end));

    always_ff @(posedge sys_clock) begin
        if (reset || (cap_abort && state != StIdle)) begin
            state      <= StIdle;
            cap_busy   <= 1'b0;
            cap_done   <= 1'b0;
            sens_xck   <= 1'b0;
            sens_reset <= 1'b1;
            sens_load  <= 1'b0;
            sens_sin   <= 1'b0;
            sens_start <= 1'b0;
            sens_read  <= 1'b0;
            pix_valid  <= 1'b0;
            pix_index  <= 14'd0;
            div_cnt    <= 8'd0;
            regs_q     <= 64'd0;
            expo_q     <= 16'd0;
            expo_cnt   <= 16'd0;
            rst_phase  <= 1'b0;
            prog_end   <= 1'b0;
            word_idx   <= 3'd0;
            bit_idx    <= 4'd10;
            pix_cnt    <= 15'd0;
        end else begin
            cap_done  <= 1'b0;
            pix_valid <= 1'b0;
            if (cap_busy) begin
                div_cnt <= wrap ? 8'd0 : div_cnt + 8'd1;
                if (wrap) begin
                    sens_xck <= ~sens_xck;
                end
            end
            if (emit) begin
                sens_sin  <= prog_word[bit_idx];
                sens_load <= (bit_idx == 4'd0);
                if (bit_idx == 4'd0) begin
                    bit_idx  <= 4'd10;
                    word_idx <= word_idx + 3'd1;
                    prog_end <= (word_idx == 3'd7);
                end else begin
                    bit_idx <= bit_idx - 4'd1;
                end
            end
            unique case (state)
                StIdle: begin
                    if (cap_req && !cap_abort) begin
                        regs_q    <= cfg_regs;
                        expo_q    <= cfg_exposure;
                        cap_busy  <= 1'b1;
                        div_cnt   <= 8'd0;
                        sens_xck  <= 1'b0;
                        pix_index <= 14'd0;
                        pix_cnt   <= 15'd0;
                        rst_phase <= 1'b0;
                        prog_end  <= 1'b0;
                        word_idx  <= 3'd0;
                        bit_idx   <= 4'd10;
                        state     <= StRst;
                    end
                end
                StRst: begin
                    if (fall) begin
                        if (!rst_phase) begin
                            sens_reset <= 1'b0;
                            rst_phase  <= 1'b1;
                        end else begin
                            sens_reset <= 1'b1;
                            state      <= StProg;
                        end
                    end
                end
                StProg: begin
                    if (fall && prog_end) begin
                        sens_sin   <= 1'b0;
                        sens_load  <= 1'b0;
                        sens_start <= 1'b1;
                        state      <= StStart;
                    end
                end
                StStart: begin
                    if (fall) begin
                        sens_start <= 1'b0;
                        if (expo_q == 16'd0) begin
                            sens_read <= 1'b1;
                            state     <= StRead;
                        end else begin
                            expo_cnt <= expo_q;
                            state    <= StExpo;
                        end
                    end
                end
                StExpo: begin
                    if (fall) begin
                        expo_cnt <= expo_cnt - 16'd1;
                        if (expo_cnt == 16'd1) begin
                            sens_read <= 1'b1;
                            state     <= StRead;
                        end
                    end
                end
                StRead: begin
                    if (rise) begin
                        pix_valid <= 1'b1;
                        pix_index <= pix_cnt[13:0];
                        pix_cnt   <= pix_cnt + 15'd1;
                    end else if (fall && pix_cnt == 15'(PIXELS)) begin
                        sens_read <= 1'b0;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    cap_done <= 1'b1;
                    cap_busy <= 1'b0;
                    sens_xck <= 1'b0;
                    div_cnt  <= 8'd0;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_gbcam_sensor_seq.sv
// Self-checking bench for gbcam_sensor_seq: every sampled cycle is compared with a
// time-based model of the capture waveform derived from XCK period arithmetic.
module tb_gbcam_sensor_seq;
    localparam int DIV_S = 2;
    localparam int PIX_S = 4;
    localparam int DIV_B = 2;
    localparam int PIX_B = 16384;
    // {busy, done, xck, reset_n, load, sin, start, read, valid, index[13:0]}
    localparam logic [22:0] RST_VEC = 23'h080000;

    logic        clk;
    logic        rst;
    logic        cap_req_s;
    logic        cap_req_b;
    logic        cap_abort;
    logic [63:0] cfg_regs;
    logic [15:0] cfg_exposure;

    logic busy_s, done_s, xck_s, srst_s, load_s, sin_s, start_s, read_s, valid_s;
    logic busy_b, done_b, xck_b, srst_b, load_b, sin_b, start_b, read_b, valid_b;
    logic [13:0] idx_s, idx_b;
    logic [22:0] obs_s, obs_b;

    int errors;
    int checks;

    int          r_mism, r_first_n, r_done, r_pix, r_last_idx, r_load, r_start;
    int          r_read_rise, r_start_fall;
    logic [22:0] r_first_got, r_first_exp;

    assign obs_s = {busy_s, done_s, xck_s, srst_s, load_s, sin_s, start_s, read_s, valid_s, idx_s};
    assign obs_b = {busy_b, done_b, xck_b, srst_b, load_b, sin_b, start_b, read_b, valid_b, idx_b};

    gbcam_sensor_seq #(.XCK_DIV(DIV_S), .PIXELS(PIX_S)) dut (
        .sys_clock(clk), .reset(rst), .cap_req(cap_req_s), .cap_abort(cap_abort),
        .cfg_regs(cfg_regs), .cfg_exposure(cfg_exposure),
        .cap_busy(busy_s), .cap_done(done_s), .sens_xck(xck_s), .sens_reset(srst_s),
        .sens_load(load_s), .sens_sin(sin_s), .sens_start(start_s), .sens_read(read_s),
        .pix_valid(valid_s), .pix_index(idx_s)
    );

    gbcam_sensor_seq #(.XCK_DIV(DIV_B), .PIXELS(PIX_B)) dut_big (
        .sys_clock(clk), .reset(rst), .cap_req(cap_req_b), .cap_abort(cap_abort),
        .cfg_regs(cfg_regs), .cfg_exposure(cfg_exposure),
        .cap_busy(busy_b), .cap_done(done_b), .sens_xck(xck_b), .sens_reset(srst_b),
        .sens_load(load_b), .sens_sin(sin_b), .sens_start(start_b), .sens_read(read_b),
        .pix_valid(valid_b), .pix_index(idx_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs n cycles after the accepting edge, from the XCK period schedule:
    // period 0 idle-like, 1 sensor reset, 2..89 serial bits, 90 start, E exposure, P read.
    function automatic logic [22:0] model(input int n, input int d, input int p, input int e,
                                          input logic [63:0] regs, input int stop_n);
        int per, ph, k, b, w, i, r0, tend;
        logic [10:0] word;
        logic busy, done, xck, rstn, load, sin, start, rd, vld;
        logic [13:0] idx;
        per = 2 * d;
        tend = per * (91 + e + p);
        r0 = 91 + e;
        {busy, done, xck, load, sin, start, rd, vld} = 8'b0;
        rstn = 1'b1;
        idx = 14'd0;
        if (n >= stop_n) return RST_VEC;
        if (n > tend) begin
            done = (n == tend + 1);
            idx = 14'(p - 1);
        end else begin
            k = n / per;
            ph = n % per;
            busy = 1'b1;
            xck = ((n / d) % 2) == 1;
            rstn = (k != 1);
            if (k >= 2 && k <= 89) begin
                b = k - 2;
                w = b / 11;
                i = 10 - (b % 11);
                word = {3'(w), regs[8*w +: 8]};
                sin = word[i];
                load = (i == 0);
            end
            start = (k == 90);
            rd = (k >= r0 && k < r0 + p);
            vld = rd && (ph == d);
            if (n >= per * r0 + d) idx = 14'((n - per * r0 - d) / per);
        end
        return {busy, done, xck, rstn, load, sin, start, rd, vld, idx};
    endfunction

    // Runs one capture, recording observations; request/abort/reset injection points are
    // cycle numbers after the accepting edge (-1 = none).
    task automatic run_cap(input bit big, input logic [63:0] regs, input int e,
                           input int req_a, input int req_b, input int abort_at, input int rst_at);
        int d, p, stop_n, last_n, tend;
        logic [22:0] got, want, prev;
        d = big ? DIV_B : DIV_S;
        p = big ? PIX_B : PIX_S;
        tend = 2 * d * (91 + e + p);
        stop_n = 1 << 30;
        if (abort_at >= 0) stop_n = abort_at + 1;
        if (rst_at >= 0) stop_n = rst_at + 1;
        last_n = (stop_n < tend) ? stop_n + 4 : tend + 4;
        r_mism = 0; r_first_n = -1; r_done = 0; r_pix = 0; r_last_idx = -1;
        r_load = 0; r_start = 0; r_read_rise = -1; r_start_fall = -1;
        r_first_got = '0; r_first_exp = '0;
        prev = RST_VEC;
        @(negedge clk);
        cfg_regs = regs;
        cfg_exposure = 16'(e);
        if (big) cap_req_b = 1'b1;
        else cap_req_s = 1'b1;
        for (int n = 0; n <= last_n; n++) begin
            @(negedge clk);
            got = big ? obs_b : obs_s;
            want = model(n, d, p, e, regs, stop_n);
            if (got !== want) begin
                r_mism++;
                if (r_mism == 1) begin
                    r_first_n = n; r_first_got = got; r_first_exp = want;
                end
            end
            if (got[21]) r_done++;
            if (got[14]) begin r_pix++; r_last_idx = int'(got[13:0]); end
            if (got[18] && !prev[18]) r_load++;
            if (got[16]) r_start++;
            if (got[15] && !prev[15]) r_read_rise = n;
            if (!got[16] && prev[16]) r_start_fall = n;
            prev = got;
            cap_req_s = 1'b0; cap_req_b = 1'b0; cap_abort = 1'b0; rst = 1'b0;
            if (n == req_a || n == req_b) begin
                if (big) cap_req_b = 1'b1;
                else cap_req_s = 1'b1;
            end
            if (n == abort_at) cap_abort = 1'b1;
            if (n == rst_at) rst = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_s !== RST_VEC) begin
            errors++; $display("FAIL reset_small: got %h want %h", obs_s, RST_VEC);
        end
        checks++;
        if (obs_b !== RST_VEC) begin
            errors++; $display("FAIL reset_big: got %h want %h", obs_b, RST_VEC);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_s !== RST_VEC) begin
            errors++; $display("FAIL reset_release_small: got %h want %h", obs_s, RST_VEC);
        end
        checks++;
        if (obs_b !== RST_VEC) begin
            errors++; $display("FAIL reset_release_big: got %h want %h", obs_b, RST_VEC);
        end
    endtask

    task automatic test_capture();
        run_cap(1'b0, 64'h8877665544332211, 3, -1, -1, -1, -1);
        checks++;
        if (r_mism !== 0) begin
            errors++; $display("FAIL capture_wave: %0d bad cycles, first n=%0d got %h want %h",
                               r_mism, r_first_n, r_first_got, r_first_exp);
        end
        checks++;
        if (r_done !== 1) begin errors++; $display("FAIL capture_done: got %0d want 1", r_done); end
        checks++;
        if (r_pix !== PIX_S) begin errors++; $display("FAIL capture_pix: got %0d want %0d", r_pix, PIX_S); end
        checks++;
        if (r_last_idx !== PIX_S - 1) begin
            errors++; $display("FAIL capture_last_idx: got %0d want %0d", r_last_idx, PIX_S - 1);
        end
        checks++;
        if (r_load !== 8) begin errors++; $display("FAIL capture_loads: got %0d want 8", r_load); end
        checks++;
        if (r_start !== 2 * DIV_S) begin
            errors++; $display("FAIL capture_start_len: got %0d want %0d", r_start, 2 * DIV_S);
        end
        checks++;
        if (r_read_rise - r_start_fall !== 3 * 2 * DIV_S) begin
            errors++; $display("FAIL capture_expo_len: got %0d want %0d",
                               r_read_rise - r_start_fall, 3 * 2 * DIV_S);
        end
        for (int t = 0; t < 3; t++) begin
            int e;
            e = int'($urandom_range(1, 6));
            run_cap(1'b0, {$urandom(), $urandom()}, e, -1, -1, -1, -1);
            checks++;
            if (r_mism !== 0) begin
                errors++; $display("FAIL random_wave e=%0d: %0d bad, first n=%0d got %h want %h",
                                   e, r_mism, r_first_n, r_first_got, r_first_exp);
            end
            checks++;
            if (r_done !== 1) begin errors++; $display("FAIL random_done: got %0d want 1", r_done); end
        end
    endtask

    task automatic test_exposure_zero();
        run_cap(1'b0, {$urandom(), $urandom()}, 0, -1, -1, -1, -1);
        checks++;
        if (r_mism !== 0) begin
            errors++; $display("FAIL expo0_wave: %0d bad, first n=%0d got %h want %h",
                               r_mism, r_first_n, r_first_got, r_first_exp);
        end
        checks++;
        if (r_read_rise !== r_start_fall) begin
            errors++; $display("FAIL expo0_read_rise: got n=%0d want n=%0d", r_read_rise, r_start_fall);
        end
    endtask

    task automatic test_back_to_back();
        run_cap(1'b0, 64'h8877665544332211, 3, 4 * DIV_S * 20 + 1, 2 * DIV_S * 95 + 1, -1, -1);
        checks++;
        if (r_mism !== 0) begin
            errors++; $display("FAIL busy_req_wave: %0d bad, first n=%0d got %h want %h",
                               r_mism, r_first_n, r_first_got, r_first_exp);
        end
        checks++;
        if (r_done !== 1) begin errors++; $display("FAIL busy_req_done: got %0d want 1", r_done); end
    endtask

    task automatic test_abort_read();
        logic [63:0] regs;
        regs = {$urandom(), $urandom()};
        run_cap(1'b0, regs, 2, -1, -1, 2 * DIV_S * 95 + DIV_S, -1);
        checks++;
        if (r_mism !== 0) begin
            errors++; $display("FAIL abort_wave: %0d bad, first n=%0d got %h want %h",
                               r_mism, r_first_n, r_first_got, r_first_exp);
        end
        checks++;
        if (r_done !== 0) begin errors++; $display("FAIL abort_done: got %0d want 0", r_done); end
        checks++;
        if (r_pix !== 3) begin errors++; $display("FAIL abort_pix: got %0d want 3", r_pix); end
        run_cap(1'b0, regs, 2, -1, -1, -1, -1);
        checks++;
        if (r_mism !== 0) begin
            errors++; $display("FAIL after_abort_wave: %0d bad, first n=%0d got %h want %h",
                               r_mism, r_first_n, r_first_got, r_first_exp);
        end
        checks++;
        if (r_done !== 1) begin errors++; $display("FAIL after_abort_done: got %0d want 1", r_done); end
    endtask

    task automatic test_reset_expo();
        run_cap(1'b0, {$urandom(), $urandom()}, 5, -1, -1, -1, 2 * DIV_S * 93 + 1);
        checks++;
        if (r_mism !== 0) begin
            errors++; $display("FAIL reset_expo_wave: %0d bad, first n=%0d got %h want %h",
                               r_mism, r_first_n, r_first_got, r_first_exp);
        end
        checks++;
        if (r_done !== 0) begin errors++; $display("FAIL reset_expo_done: got %0d want 0", r_done); end
        checks++;
        if ({srst_s, xck_s} !== 2'b10) begin
            errors++; $display("FAIL reset_expo_pins: got reset=%b xck=%b want 1 0", srst_s, xck_s);
        end
    endtask

    task automatic test_idle_req_abort();
        @(negedge clk);
        cap_req_s = 1'b1;
        cap_abort = 1'b1;
        @(negedge clk);
        cap_req_s = 1'b0;
        cap_abort = 1'b0;
        checks++;
        if (obs_s[22:14] !== 9'b000100000) begin
            errors++; $display("FAIL idle_req_abort: got %b want 000100000", obs_s[22:14]);
        end
        repeat (3 * DIV_S) @(negedge clk);
        checks++;
        if (obs_s[22:14] !== 9'b000100000) begin
            errors++; $display("FAIL idle_req_abort_later: got %b want 000100000", obs_s[22:14]);
        end
    endtask

    task automatic test_long();
        run_cap(1'b1, {$urandom(), $urandom()}, int'($urandom_range(0, 3)), -1, -1, -1, -1);
        checks++;
        if (r_mism !== 0) begin
            errors++; $display("FAIL long_wave: %0d bad, first n=%0d got %h want %h",
                               r_mism, r_first_n, r_first_got, r_first_exp);
        end
        checks++;
        if (r_pix !== PIX_B) begin errors++; $display("FAIL long_pix: got %0d want %0d", r_pix, PIX_B); end
        checks++;
        if (r_last_idx !== PIX_B - 1) begin
            errors++; $display("FAIL long_last_idx: got %0d want %0d", r_last_idx, PIX_B - 1);
        end
        checks++;
        if (r_done !== 1) begin errors++; $display("FAIL long_done: got %0d want 1", r_done); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        cap_req_s = 1'b0;
        cap_req_b = 1'b0;
        cap_abort = 1'b0;
        cfg_regs = '0;
        cfg_exposure = '0;
        test_reset();
        test_idle_req_abort();
        test_capture();
        test_exposure_zero();
        test_back_to_back();
        test_abort_read();
        test_reset_expo();
        test_long();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
